// File: rtl/first_fill_ip_wrapper_if.sv
// Bit-serial stream carrying the filled image, one pixel per beat, row 0 column 0 first.
interface first_fill_ip_wrapper_if;
  logic tvalid;
  logic tready;
  logic tdata;

  modport master (output tvalid, output tdata, input  tready);
  modport slave  (input  tvalid, input  tdata, output tready);
endinterface

// File: rtl/first_fill_ip_wrapper.sv
// Test-pattern source -> threshold -> per-row span fill -> row FIFO -> 1-bit stream.
// Define FIRST_FILL_LOOP_EN to generate frames continuously instead of one frame per reset.
module first_fill_ip_wrapper #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [7:0]  THRESH    = 8'h40,
  parameter int unsigned FIFO_ROWS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  first_fill_ip_wrapper_if.master axis,
  output logic                    Debug_Din_Valid,
  output logic                    Debug_Sel_Valid,
  output logic                    Debug_Resize,
  output logic [7:0]              m_axis_tdata,
  output logic                    oStart
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = (FIFO_ROWS > 1) ? $clog2(FIFO_ROWS) : 1;
  localparam int unsigned NW = $clog2(FIFO_ROWS + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    x_q, y_q, x_d, y_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] row_q;
  logic             row_done_q;
  logic [WIDTH-1:0] from_lo, to_hi, fill_word;
  logic [WIDTH-1:0] mem [FIFO_ROWS];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]    fifo_cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    bit_q;
  logic             busy_q;
  logic             push, pop, beat, row_full, pix_valid;
  logic [31:0]      xy;
  logic [7:0]       grey;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == FIFO_ROWS - 1) ? '0 : p + PW'(1);
  endfunction

  // A new row may start only if it is guaranteed a FIFO slot, counting the row being pushed now.
  assign row_full  = (32'(fifo_cnt_q) + 32'(push)) >= FIFO_ROWS;
  // rst_n is an active-high reset; gating here keeps the source silent while it is held.
  assign pix_valid = !rst_n && run_q && !(x_q == '0 && row_full);
  assign xy        = 32'(x_q ^ y_q);
  assign grey      = {xy[4:0], 3'b000};

  assign Debug_Din_Valid = pix_valid;
  assign m_axis_tdata    = pix_valid ? grey : 8'h00;
  assign Debug_Resize    = pix_valid && (grey >= THRESH);
  assign oStart          = pix_valid && (x_q == '0) && (y_q == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    run_d = run_q;
    if (pix_valid) begin
      if (x_q != LAST) begin
        x_d = x_q + CW'(1);
      end else begin
        x_d = '0;
        if (y_q != LAST) begin
          y_d = y_q + CW'(1);
        end else begin
          y_d = '0;
`ifdef FIRST_FILL_LOOP_EN
          run_d = 1'b1;
`else
          run_d = 1'b0;
`endif
        end
      end
    end
  end

  // from_lo: bits at or above the lowest set bit; to_hi: bits at or below the highest set bit.
  always_comb begin
    from_lo = row_q | (~row_q + WIDTH'(1));
    to_hi   = '0;
    to_hi[WIDTH-1] = row_q[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      to_hi[i] = to_hi[i+1] | row_q[i];
    end
    fill_word = from_lo & to_hi;
  end

  assign push = row_done_q;
  assign beat = busy_q && axis.tready;
  assign pop  = (fifo_cnt_q != '0) && (!busy_q || (beat && bit_q == LAST));

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      run_q      <= 1'b1;
      row_q      <= '0;
      row_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      run_q      <= run_d;
      row_done_q <= pix_valid && (x_q == LAST);
      if (pix_valid) row_q[x_q] <= Debug_Resize;

      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + NW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - NW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      if (pop) begin
        shift_q <= mem[rd_ptr_q];
        bit_q   <= '0;
        busy_q  <= 1'b1;
      end else if (beat) begin
        shift_q <= shift_q >> 1;
        bit_q   <= bit_q + CW'(1);
        if (bit_q == LAST) busy_q <= 1'b0;
      end
    end
  end

  // NOTE: row storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= fill_word;
  end

  assign axis.tvalid     = busy_q;
  assign axis.tdata      = busy_q & shift_q[0];
  assign Debug_Sel_Valid = pop;
endmodule

// File: tb/tb_first_fill_ip_wrapper.sv
// Self-checking bench for first_fill_ip_wrapper: directed phases with randomized tready.
module tb_first_fill_ip_wrapper;
  localparam int W   = 32;
  localparam int THR = 'h40;
  localparam int FR  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  first_fill_ip_wrapper_if axis();
  logic       din_valid, sel_valid, resize, ostart;
  logic [7:0] grey;

  first_fill_ip_wrapper #(.WIDTH(W), .THRESH(8'h40), .FIFO_ROWS(FR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .axis            (axis),
    .Debug_Din_Valid (din_valid),
    .Debug_Sel_Valid (sel_valid),
    .Debug_Resize    (resize),
    .m_axis_tdata    (grey),
    .oStart          (ostart)
  );

  int checks = 0;
  int errors = 0;
  bit beats[$];
  bit exp_stream[$];
  int pix_cnt, pix_err, ostart_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grey(int x, int y);
    return ((x ^ y) % 32) * 8;
  endfunction

  function automatic bit model_bin(int x, int y);
    return model_grey(x, y) >= THR;
  endfunction

  function automatic logic [W-1:0] model_row(int y);
    int lo = -1;
    int hi = -1;
    logic [W-1:0] r = '0;
    for (int x = 0; x < W; x++) begin
      if (model_bin(x, y)) begin
        if (lo < 0) lo = x;
        hi = x;
      end
    end
    if (lo >= 0) for (int x = lo; x <= hi; x++) r[x] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] beats_row(int r);
    logic [W-1:0] w = 'x;
    for (int x = 0; x < W; x++) if (r * W + x < beats.size()) w[x] = beats[r * W + x];
    return w;
  endfunction

  function automatic int stream_mismatches();
    int n = 0;
    for (int i = 0; i < exp_stream.size(); i++)
      if (i >= beats.size() || beats[i] !== exp_stream[i]) n++;
    return n;
  endfunction

  function automatic logic [12:0] all_outputs();
    return {din_valid, sel_valid, resize, ostart, grey, axis.tvalid, axis.tdata};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observe one cycle at the falling edge: collect beats and grade the pixel source.
  task automatic sample();
    int x, y;
    @(negedge clk);
    if (axis.tvalid === 1'b1 && axis.tready === 1'b1) beats.push_back(axis.tdata);
    x = pix_cnt % W;
    y = (pix_cnt / W) % W;
    if (ostart !== (din_valid === 1'b1 && x == 0 && y == 0)) ostart_err++;
    if (din_valid === 1'b1) begin
      if (grey !== 8'(model_grey(x, y)) || resize !== model_bin(x, y)) pix_err++;
      pix_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    axis.tready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("reset_outputs", 64'(all_outputs()), 64'd0);
    step();
    rst_n = 1'b0;
    beats.delete();
    pix_cnt = 0;
    pix_err = 0;
    ostart_err = 0;
  endtask

  initial begin
    int first_sel, first_tv, first_din, last_din, bad_lo, bad_hi;
    int unstable, pix_at_release;
    logic hold_tv, hold_td;

    for (int y = 0; y < W; y++) begin
      logic [W-1:0] w;
      w = model_row(y);
      for (int x = 0; x < W; x++) exp_stream.push_back(w[x]);
    end
    axis.tready = 1'b0;

    // Phase 1: tready high throughout; timing, pattern, fill and totals.
    do_reset();
    axis.tready = 1'b1;
    first_sel = -1; first_tv = -1; first_din = -1; last_din = -1;
    for (int c = 0; c < 1100; c++) begin
      sample();
      if (sel_valid === 1'b1 && first_sel < 0) first_sel = c;
      if (axis.tvalid === 1'b1 && first_tv < 0) first_tv = c;
      if (din_valid === 1'b1) begin
        if (first_din < 0) first_din = c;
        last_din = c;
      end
      step();
    end
    check("p1_pixels", 64'(pix_err), 64'd0);
    check("p1_ostart", 64'(ostart_err), 64'd0);
    check("p1_din_count", 64'(pix_cnt), 64'(W * W));
    check("p1_din_first", 64'(first_din), 64'd0);
    check("p1_din_last", 64'(last_din), 64'(W * W - 1));
    check("p1_first_sel", 64'(first_sel), 64'd33);
    check("p1_first_tvalid", 64'(first_tv), 64'd34);
    check("p1_beats", 64'(beats.size()), 64'(W * W));
    check("p1_stream", 64'(stream_mismatches()), 64'd0);
    bad_lo = 0; bad_hi = 0;
    for (int r = 0; r < 8; r++) if (beats_row(r) !== 32'hFFFF_FF00) bad_lo++;
    for (int r = 8; r < 16; r++) if (beats_row(r) !== 32'hFFFF_FFFF) bad_hi++;
    check("p1_rows_0_7", 64'(bad_lo), 64'd0);
    check("p1_rows_8_15", 64'(bad_hi), 64'd0);
`ifndef FIRST_FILL_LOOP_EN
    @(negedge clk);
    check("p1_idle_tvalid", 64'(axis.tvalid), 64'd0);
    step();
`endif

    // Phase 2: 200-cycle back-pressure after row 0 loads, then random tready.
    do_reset();
    unstable = 0; pix_at_release = -1; hold_tv = 1'b0; hold_td = 1'b0;
    for (int c = 0; c < 9000 && beats.size() < W * W; c++) begin
      if (c < 34)       axis.tready = 1'b1;
      else if (c < 234) axis.tready = 1'b0;
      else              axis.tready = 1'($urandom_range(0, 1));
      sample();
      if (c == 34) begin
        hold_tv = axis.tvalid;
        hold_td = axis.tdata;
      end else if (c > 34 && c < 234) begin
        if (axis.tvalid !== hold_tv || axis.tdata !== hold_td) unstable++;
      end
      if (c == 233) pix_at_release = pix_cnt;
      step();
    end
    repeat (60) begin
      axis.tready = 1'($urandom_range(0, 1));
      sample();
      step();
    end
    check("p2_hold_tvalid", 64'(hold_tv), 64'd1);
    check("p2_hold_stable", 64'(unstable), 64'd0);
    check("p2_stall_pixels", 64'(pix_at_release), 64'((FR + 1) * W));
    check("p2_pixels", 64'(pix_err), 64'd0);
    check("p2_beats", 64'(beats.size()), 64'(W * W));
    check("p2_stream", 64'(stream_mismatches()), 64'd0);

    // Phase 3: reset right after pixel 500, then a clean restarted frame.
    do_reset();
    for (int c = 0; c < 4000 && pix_cnt <= 500; c++) begin
      axis.tready = 1'($urandom_range(0, 1));
      sample();
      step();
    end
    check("p3_reached_500", 64'(pix_cnt), 64'd501);
    check("p3_pre_pixels", 64'(pix_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    check("p3_midreset_outputs", 64'(all_outputs()), 64'd0);
    step();
    step();
    rst_n = 1'b0;
    beats.delete();
    pix_cnt = 0; pix_err = 0; ostart_err = 0;
    axis.tready = 1'($urandom_range(0, 1));
    sample();
    check("p3_restart", 64'({ostart, din_valid, grey}), 64'({1'b1, 1'b1, 8'h00}));
    step();
    for (int c = 1; c < 9000 && beats.size() < W * W; c++) begin
      axis.tready = 1'($urandom_range(0, 1));
      sample();
      step();
    end
    repeat (60) begin
      axis.tready = 1'b1;
      sample();
      step();
    end
    check("p3_pixels", 64'(pix_err), 64'd0);
    check("p3_ostart", 64'(ostart_err), 64'd0);
    check("p3_beats", 64'(beats.size()), 64'(W * W));
    check("p3_stream", 64'(stream_mismatches()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/first_fill_ip_wrapper.md
Name: first_fill_ip_wrapper

Overview:
- Self-contained binary-image "first fill" pipeline with an on-chip test-pattern source; it needs no input data.
- A pattern generator produces one WIDTH x WIDTH 8-bit grey frame. Each pixel is thresholded to 1 bit.
- Each completed row is filled from its leftmost to its rightmost set pixel.
- Filled rows are serialized one bit per beat onto a 1-bit AXI-Stream-style master. Debug taps expose the internal stages.

Parameters:
- WIDTH, 32: image width and height in pixels; row word width.
- THRESH, 8'h40: binarization threshold; pixel bit = (grey >= THRESH).
- FIFO_ROWS, 4: depth of the filled-row FIFO, in rows.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-high reset, despite the _n suffix.
- tready  in  1  downstream ready for tdata.
- tvalid  out  1  tdata beat valid.
- tdata  out  1  filled-image bit.
- Debug_Din_Valid  out  1  source pixel valid this cycle.
- Debug_Sel_Valid  out  1  one-cycle pulse when the serializer loads a filled row.
- Debug_Resize  out  1  binarized pixel; qualified by Debug_Din_Valid.
- m_axis_tdata  out  8  grey source pixel; qualified by Debug_Din_Valid.
- oStart  out  1  one-cycle pulse on the first pixel of a frame.

Behaviour:
- Reset: all outputs 0. Coordinates, FIFO, serializer and row accumulator are cleared. Reset mid-frame aborts the frame and drops all buffered rows. The generator restarts on the first cycle after reset deasserts.
- Generator:
  - Raster order, x = column 0..WIDTH-1 inner loop, y = row outer loop.
  - Grey = {(x ^ y)[4:0], 3'b000}; that is, the 5 LSBs of x^y shifted left 3.
  - Emits one pixel per cycle with Debug_Din_Valid=1.
  - Stalls, with Din_Valid=0 and coordinates held, at the start of a row when the FIFO holds FIFO_ROWS rows.
  - First pixel after reset is cycle 0; oStart=1 in that same cycle.
  - After pixel (WIDTH-1, WIDTH-1) the generator goes idle (see Optional Feature).
- Binarize: Debug_Resize = (m_axis_tdata >= THRESH), combinational on the same cycle as the pixel.
- Row accumulate: bit x of a WIDTH-bit row word = Debug_Resize of column x.
- Fill:
  - Performed in the cycle after a row's last pixel. L = lowest set index, R = highest set index.
  - Output bits L..R are forced to 1; all other bits are 0.
  - A row with no set bits gives all zeros. A row with a single set bit gives only that bit.
  - The filled word is pushed to the FIFO at cycle 32r+32 for row r, with no stall.
- Serializer:
  - When idle and the FIFO is non-empty, it pops one word. Debug_Sel_Valid pulses for 1 cycle on the load.
  - tvalid rises the next cycle. Bit 0 (column 0) is sent first.
  - A beat transfers on tvalid && tready. tdata and tvalid hold while tready=0.
  - After bit WIDTH-1 transfers, the next word is loaded back-to-back if available; otherwise tvalid=0.
- Latency with tready=1 throughout:
  - Row r last pixel at cycle 32r+31; FIFO push at 32r+32.
  - Sel_Valid at 32r+33 if the serializer is idle; first tdata beat at 32r+34.
- Totals: exactly WIDTH*WIDTH tvalid&&tready beats per frame. Output order is row 0 column 0 first.

Optional Feature:
- Macro FIRST_FILL_LOOP_EN.
- When defined: the generator wraps to (0,0) after the last pixel and produces frames continuously, subject to FIFO back-pressure. oStart pulses at each frame start.
- When undefined: exactly one frame is produced per reset. The block then stays idle, with tvalid=0 once the FIFO and serializer drain.

Test Plan:
- Reset, then tready=1 from cycle 0: oStart=1 only at cycle 0. m_axis_tdata sequence for row 0 is 0x00,0x08,...,0xF8. Debug_Din_Valid high for 1024 consecutive cycles.
- Binarize check, default THRESH=0x40:
  - Rows 0-7: Debug_Resize=1 exactly for x>=8.
  - Rows 8-15: Debug_Resize=1 for x<=7 and x>=16.
- Fill check:
  - Rows 0-7 output word = 0xFFFFFF00 (bits 8..31 set).
  - Rows 8-15 output = 0xFFFFFFFF, with the gap 8..15 filled.
  - 1024 tdata beats captured in total.
- Latency: with tready=1, Debug_Sel_Valid first pulses at cycle 33 and the first tvalid is at cycle 34.
- Back-pressure: hold tready=0 for 200 cycles after row 0 is loaded.
  - tdata and tvalid remain stable.
  - The generator stalls after FIFO_ROWS rows are buffered.
  - After release, the output stream still equals the unstalled stream bit-for-bit.
- Reset mid-frame at pixel 500: all outputs go to 0 the next cycle. The frame restarts from (0,0) with oStart=1, and no stale rows are emitted.
